// File: rtl/dec_operand_stage.sv
// dec_operand_stage: decode/operand-fetch pipeline register with 2-entry skid, prioritised bypass and stall-time operand refresh.
module dec_operand_stage #(
  parameter int XLEN   = 32,
  parameter int NB_BYP = 2,
  parameter int CTRL_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          in_pc_i,
  input  logic [CTRL_W-1:0]        in_ctrl_i,
  input  logic                     in_rs1_v_i,
  input  logic [4:0]               in_rs1_adr_i,
  input  logic                     in_rs2_v_i,
  input  logic [4:0]               in_rs2_adr_i,
  input  logic                     in_rd_v_i,
  input  logic [4:0]               in_rd_adr_i,
  output logic [4:0]               rf_rs1_adr_o,
  output logic [4:0]               rf_rs2_adr_o,
  input  logic [XLEN-1:0]          rf_rs1_data_i,
  input  logic [XLEN-1:0]          rf_rs2_data_i,
  input  logic [NB_BYP-1:0]        byp_v_i,
  input  logic [5*NB_BYP-1:0]      byp_adr_i,
  input  logic [XLEN*NB_BYP-1:0]   byp_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [CTRL_W-1:0]        out_ctrl_o,
  output logic                     out_rs1_v_o,
  output logic [4:0]               out_rs1_adr_o,
  output logic [XLEN-1:0]          out_rs1_data_o,
  output logic                     out_rs2_v_o,
  output logic [4:0]               out_rs2_adr_o,
  output logic [XLEN-1:0]          out_rs2_data_o,
  output logic                     out_rd_v_o,
  output logic [4:0]               out_rd_adr_o
);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic              rs1_v;
    logic [4:0]        rs1_adr;
    logic [XLEN-1:0]   rs1_data;
    logic              rs2_v;
    logic [4:0]        rs2_adr;
    logic [XLEN-1:0]   rs2_data;
    logic              rd_v;
    logic [4:0]        rd_adr;
  } ent_t;
  ent_t out_q, out_d, skid_q, skid_d, in_ent, out_rf, skid_rf;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, accept, out_free;
  // Scanning from the oldest source down lets the youngest match win.
  function automatic logic [XLEN-1:0] byp_sel(input logic [4:0] adr, input logic [XLEN-1:0] dflt);
    byp_sel = dflt;
    for (int k = NB_BYP - 1; k >= 0; k--)
      if (byp_v_i[k] && byp_adr_i[k*5 +: 5] == adr) byp_sel = byp_data_i[k*XLEN +: XLEN];
  endfunction
  function automatic ent_t refresh(input ent_t e);
    refresh = e;
    if (e.rs1_v && e.rs1_adr != 5'd0) refresh.rs1_data = byp_sel(e.rs1_adr, e.rs1_data);
    if (e.rs2_v && e.rs2_adr != 5'd0) refresh.rs2_data = byp_sel(e.rs2_adr, e.rs2_data);
  endfunction
  assign in_ready_o   = ~skid_v_q & ~reset;
  assign rf_rs1_adr_o = in_rs1_adr_i;
  assign rf_rs2_adr_o = in_rs2_adr_i;
  always_comb begin
    in_ent.pc       = in_pc_i;
    in_ent.ctrl     = in_ctrl_i;
    in_ent.rs1_v    = in_rs1_v_i;
    in_ent.rs1_adr  = in_rs1_adr_i;
    in_ent.rs1_data = (in_rs1_adr_i == 5'd0) ? '0 : byp_sel(in_rs1_adr_i, rf_rs1_data_i);
    in_ent.rs2_v    = in_rs2_v_i;
    in_ent.rs2_adr  = in_rs2_adr_i;
    in_ent.rs2_data = (in_rs2_adr_i == 5'd0) ? '0 : byp_sel(in_rs2_adr_i, rf_rs2_data_i);
    in_ent.rd_v     = in_rd_v_i;
    in_ent.rd_adr   = in_rd_adr_i;
    out_rf   = refresh(out_q);
    skid_rf  = refresh(skid_q);
    out_free = ~out_v_q | out_ready_i;
    accept   = in_valid_i & in_ready_o & ~flush_i;
    out_v_d  = ~flush_i & (out_free ? (skid_v_q | accept) : 1'b1);
    out_d    = ~out_free ? out_rf : skid_v_q ? skid_rf : accept ? in_ent : out_q;
    skid_v_d = ~flush_i & ~out_free & (skid_v_q | accept);
    skid_d   = skid_v_q ? skid_rf : accept ? in_ent : skid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end
  assign out_valid_o    = out_v_q;
  assign out_pc_o       = out_q.pc;
  assign out_ctrl_o     = out_q.ctrl;
  assign out_rs1_v_o    = out_q.rs1_v;
  assign out_rs1_adr_o  = out_q.rs1_adr;
  assign out_rs1_data_o = out_q.rs1_data;
  assign out_rs2_v_o    = out_q.rs2_v;
  assign out_rs2_adr_o  = out_q.rs2_adr;
  assign out_rs2_data_o = out_q.rs2_data;
  assign out_rd_v_o     = out_q.rd_v;
  assign out_rd_adr_o   = out_q.rd_adr;
endmodule

// File: tb/tb_dec_operand_stage.sv
// tb_dec_operand_stage: directed plus random stimulus checked against a queue-based model of the stage.
module tb_dec_operand_stage;
  localparam int XLEN = 32, NB = 2, CW = 64;
  logic clk = 1'b0, reset, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [XLEN-1:0] in_pc_i, rf_rs1_data_i, rf_rs2_data_i, out_pc_o, out_rs1_data_o, out_rs2_data_o;
  logic [CW-1:0] in_ctrl_i, out_ctrl_o;
  logic in_rs1_v_i, in_rs2_v_i, in_rd_v_i, out_rs1_v_o, out_rs2_v_o, out_rd_v_o;
  logic [4:0] in_rs1_adr_i, in_rs2_adr_i, in_rd_adr_i, rf_rs1_adr_o, rf_rs2_adr_o;
  logic [4:0] out_rs1_adr_o, out_rs2_adr_o, out_rd_adr_o;
  logic [NB-1:0] byp_v_i;
  logic [5*NB-1:0] byp_adr_i;
  logic [XLEN*NB-1:0] byp_data_i;
  int checks = 0, errors = 0;

  dec_operand_stage #(.XLEN(XLEN), .NB_BYP(NB), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_ctrl_i(in_ctrl_i), .in_rs1_v_i(in_rs1_v_i), .in_rs1_adr_i(in_rs1_adr_i),
    .in_rs2_v_i(in_rs2_v_i), .in_rs2_adr_i(in_rs2_adr_i), .in_rd_v_i(in_rd_v_i), .in_rd_adr_i(in_rd_adr_i),
    .rf_rs1_adr_o(rf_rs1_adr_o), .rf_rs2_adr_o(rf_rs2_adr_o), .rf_rs1_data_i(rf_rs1_data_i),
    .rf_rs2_data_i(rf_rs2_data_i), .byp_v_i(byp_v_i), .byp_adr_i(byp_adr_i), .byp_data_i(byp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_ctrl_o(out_ctrl_o),
    .out_rs1_v_o(out_rs1_v_o), .out_rs1_adr_o(out_rs1_adr_o), .out_rs1_data_o(out_rs1_data_o),
    .out_rs2_v_o(out_rs2_v_o), .out_rs2_adr_o(out_rs2_adr_o), .out_rs2_data_o(out_rs2_data_o),
    .out_rd_v_o(out_rd_v_o), .out_rd_adr_o(out_rd_adr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   ctrl;
    logic            r1v, r2v, rdv;
    logic [4:0]      r1a, r2a, rda;
    logic [XLEN-1:0] r1d, r2d;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [4:0] a, input logic [XLEN-1:0] dflt);
    if (a == 5'd0) return '0;
    for (int k = 0; k < NB; k++)
      if (byp_v_i[k] && byp_adr_i[k*5 +: 5] == a) return byp_data_i[k*XLEN +: XLEN];
    return dflt;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready_o, q.size() < 2 && !reset);
    chk("rf_rs1_adr", rf_rs1_adr_o, in_rs1_adr_i);
    chk("rf_rs2_adr", rf_rs2_adr_o, in_rs2_adr_i);
    chk("out_valid", out_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("pc", out_pc_o, q[0].pc);
      chk("ctrl", out_ctrl_o, q[0].ctrl);
      chk("rs1_v", out_rs1_v_o, q[0].r1v);
      chk("rs1_adr", out_rs1_adr_o, q[0].r1a);
      chk("rs2_v", out_rs2_v_o, q[0].r2v);
      chk("rs2_adr", out_rs2_adr_o, q[0].r2a);
      chk("rd_v", out_rd_v_o, q[0].rdv);
      chk("rd_adr", out_rd_adr_o, q[0].rda);
      if (q[0].r1v) chk("rs1_data", out_rs1_data_o, q[0].r1d);
      if (q[0].r2v) chk("rs2_data", out_rs2_data_o, q[0].r2d);
    end
  endtask

  task automatic model_update();
    ent_t e;
    bit acc;
    if (reset || flush_i) begin
      q.delete();
      return;
    end
    acc = in_valid_i && q.size() < 2;
    foreach (q[i]) begin
      if (q[i].r1v && q[i].r1a != 0) q[i].r1d = pick(q[i].r1a, q[i].r1d);
      if (q[i].r2v && q[i].r2a != 0) q[i].r2d = pick(q[i].r2a, q[i].r2d);
    end
    if (q.size() > 0 && out_ready_i) void'(q.pop_front());
    if (acc) begin
      e.pc = in_pc_i; e.ctrl = in_ctrl_i;
      e.r1v = in_rs1_v_i; e.r1a = in_rs1_adr_i; e.r1d = pick(in_rs1_adr_i, rf_rs1_data_i);
      e.r2v = in_rs2_v_i; e.r2a = in_rs2_adr_i; e.r2d = pick(in_rs2_adr_i, rf_rs2_data_i);
      e.rdv = in_rd_v_i; e.rda = in_rd_adr_i;
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    in_pc_i = '0; in_ctrl_i = '0; in_rs1_v_i = 0; in_rs2_v_i = 0; in_rd_v_i = 0;
    in_rs1_adr_i = 0; in_rs2_adr_i = 0; in_rd_adr_i = 0;
    rf_rs1_data_i = '0; rf_rs2_data_i = '0; byp_v_i = '0; byp_adr_i = '0; byp_data_i = '0;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [4:0] a1, input logic [4:0] a2);
    in_valid_i = 1; in_pc_i = pc; in_ctrl_i = {pc, ~pc};
    in_rs1_v_i = 1; in_rs1_adr_i = a1; in_rs2_v_i = 1; in_rs2_adr_i = a2;
    in_rd_v_i = 1; in_rd_adr_i = a1 ^ a2;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    cycle();
    #1 chk("rst_ready", in_ready_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_pc", out_pc_o, 0);
    chk("rst_ctrl", out_ctrl_o, 0);
    // Basic accept, RF data with no bypass.
    reset = 0; out_ready_i = 1; push(32'h100, 5, 0); rf_rs1_data_i = 32'h11;
    cycle();
    in_valid_i = 0;
    chk("s1_valid", out_valid_o, 1);
    chk("s1_data", out_rs1_data_o, 32'h11);
    // Bypass priority and x0 suppression.
    push(32'h200, 7, 0); byp_v_i = 2'b11; byp_adr_i = {5'd7, 5'd7}; byp_data_i = {32'hBB, 32'hAA};
    cycle();
    chk("s2_prio", out_rs1_data_o, 32'hAA);
    push(32'h204, 0, 0);
    cycle();
    chk("s2_x0", out_rs1_data_o, 0);
    idle(); out_ready_i = 1;
    cycle();
    // Stalled entry gets refreshed from a later bypass.
    push(32'h300, 1, 3); rf_rs2_data_i = 32'h77;
    out_ready_i = 0;
    cycle();
    in_valid_i = 0;
    cycle();
    cycle();
    byp_v_i = 2'b10; byp_adr_i = {5'd3, 5'd9}; byp_data_i = {32'h55, 32'h66};
    cycle();
    byp_v_i = 0;
    chk("s3_refresh", out_rs2_data_o, 32'h55);
    chk("s3_pc", out_pc_o, 32'h300);
    chk("s3_ctrl", out_ctrl_o, {32'h300, ~32'h300});
    out_ready_i = 1;
    cycle();
    // Skid ordering A, B, C.
    out_ready_i = 0; push(32'hA0, 1, 2);
    cycle();
    push(32'hB0, 3, 4);
    cycle();
    push(32'hC0, 5, 6);
    #1 chk("s4_full_ready", in_ready_o, 0);
    cycle();
    out_ready_i = 1;
    chk("s4_a", out_pc_o, 32'hA0);
    cycle();
    chk("s4_b", out_pc_o, 32'hB0);
    cycle();
    in_valid_i = 0;
    chk("s4_c", out_pc_o, 32'hC0);
    chk("s4_c_valid", out_valid_o, 1);
    cycle();
    // Flush with both entries held and a pending input.
    out_ready_i = 0; push(32'hD0, 1, 1);
    cycle();
    push(32'hD4, 2, 2);
    cycle();
    push(32'hD8, 3, 3); flush_i = 1;
    cycle();
    flush_i = 0; in_valid_i = 0;
    chk("s5_valid", out_valid_o, 0);
    #1 chk("s5_ready", in_ready_o, 1);
    cycle();
    chk("s5_nocap", out_valid_o, 0);
    // Reset while stalled with two entries.
    push(32'hE0, 4, 5); rf_rs1_data_i = 32'h12;
    cycle();
    push(32'hE4, 6, 7);
    cycle();
    in_valid_i = 0; reset = 1;
    cycle();
    chk("s6_valid", out_valid_o, 0);
    chk("s6_pc", out_pc_o, 0);
    chk("s6_rs1", out_rs1_data_o, 0);
    chk("s6_ctrl", out_ctrl_o, 0);
    reset = 0; out_ready_i = 1; push(32'h100, 5, 0); rf_rs1_data_i = 32'h11;
    cycle();
    in_valid_i = 0;
    chk("s6_post_valid", out_valid_o, 1);
    chk("s6_post_data", out_rs1_data_o, 32'h11);
    // Randomised traffic with small register indices to force bypass hits.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      flush_i = ($urandom_range(0, 29) == 0);
      in_valid_i = ($urandom_range(0, 9) < 7);
      out_ready_i = $urandom_range(0, 1);
      in_pc_i = $urandom; in_ctrl_i = {$urandom, $urandom};
      in_rs1_v_i = $urandom_range(0, 1); in_rs1_adr_i = 5'($urandom_range(0, 7));
      in_rs2_v_i = $urandom_range(0, 1); in_rs2_adr_i = 5'($urandom_range(0, 7));
      in_rd_v_i = $urandom_range(0, 1); in_rd_adr_i = 5'($urandom_range(0, 31));
      rf_rs1_data_i = $urandom; rf_rs2_data_i = $urandom;
      byp_v_i = 2'($urandom_range(0, 3));
      byp_adr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      byp_data_i = {$urandom, $urandom};
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_operand_stage.md
Name: dec_operand_stage

Overview:
- Parametrised decode/operand-fetch pipeline register between the decoder and dec1. Successor to the single-flop decode stage.
- Adds a valid/ready handshake with a 2-entry skid (output register + skid register).
- Adds NB_BYP prioritised bypass sources and flush.
- Adds continuous bypass refresh of operands held while the stage is stalled, so a stalled instruction never issues stale register data.

Parameters:
XLEN, 32, data/PC width
NB_BYP, 2, number of writeback bypass sources; index 0 = youngest = highest priority
CTRL_W, 64, width of opaque decoded-control bundle carried alongside operands

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush_i  in  1  branch/exception flush, kills all held entries
in_valid_i  in  1  decoder has an instruction
in_ready_o  out  1  stage can accept this cycle
in_pc_i  in  XLEN  instruction PC
in_ctrl_i  in  CTRL_W  decoded control bundle (opaque)
in_rs1_v_i / in_rs2_v_i  in  1  source operand used
in_rs1_adr_i / in_rs2_adr_i  in  5  source register index
in_rd_v_i  in  1  destination written
in_rd_adr_i  in  5  destination index
rf_rs1_adr_o / rf_rs2_adr_o  out  5  RF read address (= in_rs*_adr_i, combinational)
rf_rs1_data_i / rf_rs2_data_i  in  XLEN  RF read data, same cycle
byp_v_i  in  NB_BYP  bypass source k valid
byp_adr_i  in  5*NB_BYP  bypass k destination index, slice k
byp_data_i  in  XLEN*NB_BYP  bypass k data, slice k
out_valid_o  out  1  instruction available to dec1
out_ready_i  in  1  dec1 consumes
out_pc_o  out  XLEN
out_ctrl_o  out  CTRL_W
out_rs1_v_o, out_rs1_adr_o, out_rs1_data_o  out  1/5/XLEN
out_rs2_v_o, out_rs2_adr_o, out_rs2_data_o  out  1/5/XLEN
out_rd_v_o, out_rd_adr_o  out  1/5

Behaviour:
- Reset (reset=1 at posedge):
  - out_valid_o=0 and skid valid=0.
  - All out_* data/ctrl/pc/adr fields = 0.
  - in_ready_o=0 combinationally while reset is high.
  - Reset mid-stall discards both entries.
- in_ready_o = ~skid_v & ~reset.
- Accept = in_valid_i & in_ready_o & ~flush_i.
- Operand select at accept, per source s:
  - adr==0 -> data 0, never bypassed.
  - Otherwise the lowest k with byp_v_i[k] & byp_adr_i[k]==adr supplies byp_data_i[k].
  - Otherwise rf_rs*_data_i.
  - The select is evaluated even if rs*_v=0; data is don't-care then, but adr is still stored.
- Refresh: each cycle, every held valid entry (output reg and skid) with rs*_v=1 and adr!=0 re-applies the same priority compare. On a match, data is overwritten. With no match, data is held. The output register is refreshed only if it is not consumed that cycle.
- Skid movement, evaluated per cycle:
  - If out empty or out_ready_i=1: the output reg loads skid if skid_v, else the accepted input, else goes invalid.
  - An accepted input that cannot go to the output reg (out valid & ~out_ready_i, or skid draining into out) loads skid.
  - Ordering is preserved: skid always drains before new input.
- Latency: 1 cycle from accept to out_valid_o when unstalled. Full throughput of 1/cycle with out_ready_i=1.
- Flush:
  - out_valid_o and skid_v are cleared at the next edge.
  - Input is not accepted in the flush cycle.
  - flush_i has priority over reset-free accept and over out_ready_i; the consumed instruction that cycle is still seen by dec1 combinationally.
- Stability: while out_valid_o=1 & out_ready_i=0, pc/ctrl/adr/v fields are stable. Only rs*_data may change, and only via refresh.

Test Plan:
- Reset then in_valid with rs1=5, RF=0x11, no bypass; out_ready=1 -> next cycle out_valid=1, rs1_data=0x11; in_ready=0 throughout reset.
- Accept rs1=7 with byp0=(7,0xAA) and byp1=(7,0xBB) both valid -> rs1_data=0xAA; same with rs1=0 -> data 0.
- Stall: out_ready=0 with held rs2=3; byp1=(3,0x55) two cycles later -> out_rs2_data becomes 0x55 the following cycle; pc/ctrl unchanged; out_ready=1 then issues 0x55.
- Back-to-back A,B,C with out_ready=0 -> A in out, B in skid, in_ready=0, C held upstream; out_ready=1 for 3 cycles -> order A,B,C with no bubble after the first release.
- Flush with out and skid full plus in_valid -> next cycle out_valid=0, in_ready=1, the flush-cycle input is not captured.
- Reset asserted while stalled with 2 entries -> all outputs 0 next cycle; first post-reset accept behaves as in the first scenario.
